// File: rtl/pipe_pkg.sv
// Shared pipeline types and constants.
// Fetch FSM encoding and the IF/ID bundle used by decode.
package pipe_pkg;

    localparam int PC_BITS = 32;
    localparam int INSTR_W = 32;

    localparam logic [INSTR_W-1:0] NOP = 32'h0000_0000;

    typedef enum logic {
        HALT = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic                valid;
        logic [INSTR_W-1:0]  instr;
        logic [PC_BITS-1:0]  pc4;
    } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
// Bubble beats hold; otherwise load the fetched word.
module if_id_reg
    import pipe_pkg::*;
#(
    parameter int                 PC_W      = PC_BITS,
    parameter logic [INSTR_W-1:0] NOP_INSTR = NOP
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               bubble,
    input  logic               hold,
    input  logic [INSTR_W-1:0] nxt_instr,
    input  logic [PC_W-1:0]    nxt_pc4,
    output logic               valid,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    pc4
);

    // Bubble keeps pc4 so decode still sees the last sequential PC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            instr <= NOP_INSTR;
            pc4   <= '0;
        end else if (bubble) begin
            valid <= 1'b0;
            instr <= NOP_INSTR;
        end else if (!hold) begin
            valid <= 1'b1;
            instr <= nxt_instr;
            pc4   <= nxt_pc4;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, run/halt FSM, fetch counter.
// Memory is addressed with pc_next so rdata always matches pc.
module fetch_stage
    import pipe_pkg::*;
#(
    parameter int                 PC_W      = PC_BITS,
    parameter int                 IMEM_AW   = 8,
    parameter logic [PC_W-1:0]    RESET_PC  = '0,
    parameter logic [INSTR_W-1:0] NOP_INSTR = NOP,
    parameter int                 CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               inicio,
    input  logic               halt_req,
    input  logic               stall,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               imem_en,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               if_id_valid,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [PC_W-1:0]    if_id_pc4,
    output logic               running,
    output logic [CNT_W-1:0]   fetch_count
);

    fetch_state_t     state_q;
    logic [PC_W-1:0]  pc_q;
    logic [PC_W-1:0]  pc_next;
    logic [PC_W-1:0]  pc_inc;
    logic [PC_W-1:0]  target;
    logic [CNT_W-1:0] cnt_q;
    logic             run;
    logic             halt_take;
    logic             bubble;
    logic             load;

    assign run     = (state_q == RUN);
    assign pc_inc  = pc_q + PC_W'(4);
    assign target  = redirect_pc & ~PC_W'(3);

    // A halt on a redirected (wrong) path or under stall is ignored.
    assign halt_take = run & halt_req & ~stall
                     & ~redirect & ~inicio;

    assign bubble = inicio | redirect | ~run | halt_take;
    assign load   = ~bubble & ~stall;

    // Next PC, restart first, then redirect, then hold, else +4.
    always_comb begin
        pc_next = pc_inc;
        if (inicio)
            pc_next = RESET_PC;
        else if (!run)
            pc_next = pc_q;
        else if (redirect)
            pc_next = target;
        else if (stall | halt_req)
            pc_next = pc_q;
    end

    assign imem_addr = pc_next[IMEM_AW+1:2];
    assign imem_en   = inicio | run;

    // PC register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pc_q <= RESET_PC;
        else
            pc_q <= pc_next;
    end

    // Run/halt FSM; running is the state flop itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= HALT;
        else if (inicio)
            state_q <= RUN;
        else if (halt_take)
            state_q <= HALT;
    end

    // Saturating count of valid IF/ID captures.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else if (inicio)
            cnt_q <= '0;
        else if (load && (cnt_q != '1))
            cnt_q <= cnt_q + CNT_W'(1);
    end

    assign running     = run;
    assign fetch_count = cnt_q;

    if_id_reg #(
        .PC_W      (PC_W),
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk       (clk),
        .rst_n     (rst_n),
        .bubble    (bubble),
        .hold      (stall),
        .nxt_instr (imem_rdata),
        .nxt_pc4   (pc_inc),
        .valid     (if_id_valid),
        .instr     (if_id_instr),
        .pc4       (if_id_pc4)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: default build plus a narrow
// PC_W=8 / CNT_W=2 build, both against a cycle-level model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        inicio = 1'b0;
    logic        halt_req = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;

    logic        a_en, a_v, a_run;
    logic [7:0]  a_addr;
    logic [31:0] a_rdata, a_instr, a_pc4;
    logic [15:0] a_cnt;

    logic        b_en, b_v, b_run;
    logic [5:0]  b_addr;
    logic [31:0] b_rdata, b_instr;
    logic [7:0]  b_pc4;
    logic [1:0]  b_cnt;

    logic [31:0] mem [256];

    int total = 0;
    int bad   = 0;

    logic        m_run  [2];
    logic        m_v    [2];
    logic [31:0] m_pc   [2];
    logic [31:0] m_instr[2];
    logic [31:0] m_pc4  [2];
    int          m_cnt  [2];
    logic [31:0] pmask  [2];
    int          amask  [2];
    int          cmax   [2];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (a_en) a_rdata <= mem[a_addr];
        if (b_en) b_rdata <= mem[{2'b00, b_addr}];
    end

    fetch_stage u_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .inicio      (inicio),
        .halt_req    (halt_req),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_en     (a_en),
        .imem_addr   (a_addr),
        .imem_rdata  (a_rdata),
        .if_id_valid (a_v),
        .if_id_instr (a_instr),
        .if_id_pc4   (a_pc4),
        .running     (a_run),
        .fetch_count (a_cnt)
    );

    fetch_stage #(
        .PC_W    (8),
        .IMEM_AW (6),
        .CNT_W   (2)
    ) u_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .inicio      (inicio),
        .halt_req    (halt_req),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc[7:0]),
        .imem_en     (b_en),
        .imem_addr   (b_addr),
        .imem_rdata  (b_rdata),
        .if_id_valid (b_v),
        .if_id_instr (b_instr),
        .if_id_pc4   (b_pc4),
        .running     (b_run),
        .fetch_count (b_cnt)
    );

    task automatic check(string tag, logic [63:0] got,
                         logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_run[k]   = 1'b0;
            m_v[k]     = 1'b0;
            m_pc[k]    = '0;
            m_instr[k] = '0;
            m_pc4[k]   = '0;
            m_cnt[k]   = 0;
        end
    endtask

    // One clock of the pipeline as seen from outside.
    task automatic model_step(int k);
        logic [31:0] p;
        p = m_pc[k];
        if (inicio) begin
            m_run[k]   = 1'b1;
            m_pc[k]    = '0;
            m_v[k]     = 1'b0;
            m_instr[k] = '0;
            m_cnt[k]   = 0;
        end else if (!m_run[k]) begin
            m_v[k]     = 1'b0;
            m_instr[k] = '0;
        end else if (redirect) begin
            m_pc[k]    = redirect_pc & pmask[k] & ~32'd3;
            m_v[k]     = 1'b0;
            m_instr[k] = '0;
        end else if (stall) begin
            m_pc[k]    = p;
        end else if (halt_req) begin
            m_run[k]   = 1'b0;
            m_v[k]     = 1'b0;
            m_instr[k] = '0;
        end else begin
            m_v[k]     = 1'b1;
            m_instr[k] = mem[(p >> 2) & amask[k]];
            m_pc4[k]   = (p + 4) & pmask[k];
            m_pc[k]    = m_pc4[k];
            if (m_cnt[k] < cmax[k]) m_cnt[k]++;
        end
    endtask

    task automatic check_regs();
        check("valid_a", a_v, m_v[0]);
        check("instr_a", a_instr, m_instr[0]);
        check("pc4_a", a_pc4, m_pc4[0]);
        check("run_a", a_run, m_run[0]);
        check("cnt_a", a_cnt, m_cnt[0]);
        check("valid_b", b_v, m_v[1]);
        check("instr_b", b_instr, m_instr[1]);
        check("pc4_b", b_pc4, m_pc4[1]);
        check("run_b", b_run, m_run[1]);
        check("cnt_b", b_cnt, m_cnt[1]);
    endtask

    // Called at a negedge with inputs already applied.
    task automatic cycle();
        logic en0, en1;
        en0 = inicio | m_run[0];
        en1 = inicio | m_run[1];
        model_step(0);
        model_step(1);
        #1;
        check("en_a", a_en, en0);
        check("addr_a", a_addr, (m_pc[0] >> 2) & amask[0]);
        check("en_b", b_en, en1);
        check("addr_b", b_addr, (m_pc[1] >> 2) & amask[1]);
        @(posedge clk);
        #1;
        check_regs();
        @(negedge clk);
    endtask

    task automatic drive(logic i, logic h, logic s,
                         logic r, logic [31:0] rp);
        inicio      = i;
        halt_req    = h;
        stall       = s;
        redirect    = r;
        redirect_pc = rp;
        cycle();
    endtask

    task automatic idle(int n);
        for (int j = 0; j < n; j++)
            drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    // Reset dropped between edges; outputs must clear at once.
    task automatic async_reset();
        inicio   = 1'b0;
        halt_req = 1'b0;
        stall    = 1'b0;
        redirect = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_regs();
        check("en_rst_a", a_en, 1'b0);
        check("addr_rst_a", a_addr, 8'h0);
        check("en_rst_b", b_en, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        pmask[0] = 32'hFFFF_FFFF;
        pmask[1] = 32'h0000_00FF;
        amask[0] = 255;
        amask[1] = 63;
        cmax[0]  = 65535;
        cmax[1]  = 3;
        for (int i = 0; i < 256; i++)
            mem[i] = i + 1;
        model_reset();

        @(negedge clk);
        check_regs();
        check("en_por_a", a_en, 1'b0);
        rst_n = 1'b1;
        idle(2);

        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        idle(3);
        for (int j = 0; j < 3; j++)
            drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        idle(2);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h40);
        idle(3);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h43);
        idle(2);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h80);
        idle(2);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h20);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        idle(3);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h30);
        idle(4);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFF0);
        idle(8);

        async_reset();
        for (int i = 0; i < 256; i++)
            mem[i] = $urandom;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);

        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) begin
                async_reset();
                drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
            end
            drive($urandom_range(0, 99) < 3,
                  $urandom_range(0, 99) < 5,
                  $urandom_range(0, 99) < 20,
                  $urandom_range(0, 99) < 10,
                  $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
